// File: rtl/note_scheduler.sv
// Polyphonic voice scheduler: scans the 12 debounced keys round-robin, turns
// level changes into press/release events, and maps held notes onto
// NUM_VOICES voice slots, stealing the oldest slot when all are busy.
module note_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [11:0]             keys,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic [3:0]              scan_idx
);

    localparam int unsigned SLOT_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);
    localparam logic [3:0] LAST_KEY = 4'd11;

    logic [11:0]            key_prev;
    logic [AGE_W-1:0]       age [NUM_VOICES];

    logic [3:0]             scan_idx_d;
    logic [11:0]            key_prev_d;
    logic [4*NUM_VOICES-1:0] voice_note_d;
    logic [NUM_VOICES-1:0]  voice_active_d;
    logic [NUM_VOICES-1:0]  voice_trig_d;
    logic [AGE_W-1:0]       age_d [NUM_VOICES];

    logic                   cur_key;
    logic                   prev_key;
    logic                   press;
    logic                   release_ev;

    logic                   free_found;
    logic [SLOT_W-1:0]      free_slot;
    logic [SLOT_W-1:0]      old_slot;
    logic [AGE_W-1:0]       old_age;
    logic [SLOT_W-1:0]      alloc_slot;

    // Event detection for the key under the scan pointer.
    always_comb begin
        cur_key    = keys[scan_idx];
        prev_key   = key_prev[scan_idx];
        press      = cur_key & ~prev_key;
        release_ev = ~cur_key & prev_key;
    end

    // Scan pointer wraps 11 -> 0; only the scanned key's history bit is refreshed.
    always_comb begin
        scan_idx_d           = (scan_idx == LAST_KEY) ? 4'd0 : scan_idx + 4'd1;
        key_prev_d           = key_prev;
        key_prev_d[scan_idx] = cur_key;
    end

    // Lowest-index inactive slot; descending walk so the lowest match wins.
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active[v]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(v);
            end
        end
    end

    // Oldest slot; strict compare keeps the lowest index on equal age.
    // Only consulted when every slot is active, so no active mask is needed.
    always_comb begin
        old_slot = '0;
        old_age  = age[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age[v] > old_age) begin
                old_slot = SLOT_W'(v);
                old_age  = age[v];
            end
        end
        alloc_slot = free_found ? free_slot : old_slot;
    end

    // Next slot state: allocate on press, free matching slots on release.
    always_comb begin
        voice_note_d   = voice_note;
        voice_active_d = voice_active;
        voice_trig_d   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            age_d[v] = age[v];
        end

        if (press) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (SLOT_W'(v) == alloc_slot) begin
                    voice_note_d[4*v +: 4] = scan_idx;
                    voice_active_d[v]      = 1'b1;
                    voice_trig_d[v]        = 1'b1;
                    age_d[v]               = '0;
                end else if (voice_active[v] && (age[v] != AGE_MAX)) begin
                    age_d[v] = age[v] + 1'b1;
                end
            end
        end else if (release_ev) begin
            // Note index is kept so the release tail stays on pitch.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_active[v] && (voice_note[4*v +: 4] == scan_idx)) begin
                    voice_active_d[v] = 1'b0;
                    age_d[v]          = '0;
                end
            end
        end
    end

    // Scan pointer and key history registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scan_idx <= '0;
            key_prev <= '0;
        end else begin
            scan_idx <= scan_idx_d;
            key_prev <= key_prev_d;
        end
    end

    // Voice slot registers, all outputs registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            voice_note   <= '0;
            voice_active <= '0;
            voice_trig   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                age[v] <= '0;
            end
        end else begin
            voice_note   <= voice_note_d;
            voice_active <= voice_active_d;
            voice_trig   <= voice_trig_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                age[v] <= age_d[v];
            end
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed key patterns, expected trig events queued
// by the stimulus and consumed by a monitor on every voice_trig pulse.
module tb_note_scheduler;

    localparam int NV = 4;

    logic          clk;
    logic          n_rst;
    logic [11:0]   keys;
    logic [4*NV-1:0] voice_note;
    logic [NV-1:0] voice_active;
    logic [NV-1:0] voice_trig;
    logic [3:0]    scan_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int slot;
        int note;
    } trig_t;

    trig_t exp_q[$];

    note_scheduler #(
        .NUM_VOICES(NV)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .keys         (keys),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .voice_trig   (voice_trig),
        .scan_idx     (scan_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int slot, input int note);
        trig_t e;
        e.slot = slot;
        e.note = note;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Align to a negedge where scan_idx==0 so the next examined key is C.
    task automatic wait_scan_zero();
        for (int i = 0; i < 24 && scan_idx != 4'd0; i++) @(negedge clk);
        check("scan align", {28'd0, scan_idx}, 32'd0);
    endtask

    // Monitor: every trig pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (n_rst) begin
            for (int v = 0; v < NV; v++) begin
                if (voice_trig[v]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected trig: slot %0d note %0d, none expected",
                                 v, voice_note[4*v +: 4]);
                    end else begin
                        trig_t e;
                        e = exp_q.pop_front();
                        check("trig slot", v, e.slot);
                        check("trig note", {28'd0, voice_note[4*v +: 4]}, e.note);
                        check("trig active", {31'd0, voice_active[v]}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1);
    end

    initial begin
        int exp_scan;
        n_rst = 1'b0;
        keys  = 12'h000;
        #1;
        check("reset scan", {28'd0, scan_idx}, 32'd0);
        check("reset active", {28'd0, voice_active}, 32'd0);
        check("reset note", {16'd0, voice_note}, 32'd0);
        check("reset trig", {28'd0, voice_trig}, 32'd0);
        wait_cycles(3);
        n_rst = 1'b1;

        // Idle scanning: pointer wraps 11 -> 0, nothing allocated.
        exp_scan = 0;
        check("idle scan", {28'd0, scan_idx}, exp_scan);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            exp_scan = (exp_scan + 1) % 12;
            check("idle scan", {28'd0, scan_idx}, exp_scan);
            check("idle outputs", {voice_note, voice_active, voice_trig}, 32'd0);
        end

        // Single C press then release.
        keys = 12'h001;
        push(0, 0);
        wait_cycles(15);
        check("C active", {28'd0, voice_active}, 32'h1);
        check("C note", {16'd0, voice_note}, 32'h0000);
        keys = 12'h000;
        wait_cycles(15);
        check("C released active", {28'd0, voice_active}, 32'h0);
        check("C released note", {16'd0, voice_note}, 32'h0000);

        // Chord C, E, G, A into slots 0..3.
        keys = 12'h001; push(0, 0); wait_cycles(15);
        keys = 12'h011; push(1, 4); wait_cycles(15);
        keys = 12'h091; push(2, 7); wait_cycles(15);
        keys = 12'h291; push(3, 9); wait_cycles(15);
        check("chord notes", {16'd0, voice_note}, 32'h9740);
        check("chord active", {28'd0, voice_active}, 32'hF);

        // B steals slot 0 (oldest); later C release is a no-op.
        keys = 12'hA91; push(0, 11); wait_cycles(15);
        check("steal notes", {16'd0, voice_note}, 32'h974B);
        check("steal active", {28'd0, voice_active}, 32'hF);
        keys = 12'hA90; wait_cycles(15);
        check("stolen release notes", {16'd0, voice_note}, 32'h974B);
        check("stolen release active", {28'd0, voice_active}, 32'hF);

        // Release everything: notes hold, slots go idle.
        keys = 12'h000; wait_cycles(15);
        check("all off active", {28'd0, voice_active}, 32'h0);
        check("all off notes", {16'd0, voice_note}, 32'h974B);

        // All twelve keys at once from idle, aligned so C is scanned first.
        wait_scan_zero();
        keys = 12'hFFF;
        for (int k = 0; k < 12; k++) push(k % 4, k);
        wait_cycles(15);
        check("all keys notes", {16'd0, voice_note}, 32'hBA98);
        check("all keys active", {28'd0, voice_active}, 32'hF);

        keys = 12'h000; wait_cycles(15);
        check("idle again active", {28'd0, voice_active}, 32'h0);

        // Three voices, then reset mid-operation with keys still held.
        wait_scan_zero();
        keys = 12'h091;
        push(0, 0); push(1, 4); push(2, 7);
        wait_cycles(15);
        check("pre-reset notes", {16'd0, voice_note}, 32'hB740);
        check("pre-reset active", {28'd0, voice_active}, 32'h7);
        check("queue empty before reset", exp_q.size(), 32'd0);
        n_rst = 1'b0;
        #1;
        check("async reset active", {28'd0, voice_active}, 32'h0);
        check("async reset notes", {16'd0, voice_note}, 32'h0);
        check("async reset scan", {28'd0, scan_idx}, 32'h0);
        check("async reset trig", {28'd0, voice_trig}, 32'h0);
        wait_cycles(2);
        push(0, 0); push(1, 4); push(2, 7);
        n_rst = 1'b1;
        wait_cycles(15);
        check("post-reset notes", {16'd0, voice_note}, 32'h0740);
        check("post-reset active", {28'd0, voice_active}, 32'h7);

        keys = 12'h000;
        wait_cycles(15);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
